digi_ota_scheduler: RTL and testbench
=====================================

Name: digi_ota_scheduler

Overview:
- Time-shares one standard-cell digital OTA/comparator core between NCH requesting input channels.
- Round-robin arbitration picks a channel, which the block then sequences through four steps:
  - drives the OTA input mux select and output-driver enable;
  - waits a settle interval;
  - samples the OTA outputs over a fixed measurement window;
  - reports the counts through a valid/ready result port.
- Sits between channel front-ends and the OTA core at the tile top level.

Parameters:
- NCH, 4, number of requesting channels (2..8).
- SETTLE, 4, settle cycles after channel select (must be >= 2, covers synchronizer depth).
- WIN, 64, measurement window length in cycles (must be >= 1).
- SELW, $clog2(NCH), width of channel index.
- CW, $clog2(WIN+1), width of result counters.

Ports:
- clk, input, 1, single clock domain.
- rst, input, 1, asynchronous active-high reset.
- ch_req, input, NCH, level request per channel.
- ch_gnt, output, NCH, one-hot grant; held during SETTLE and MEASURE.
- ota_sel, output, SELW, OTA input mux select (index of granted channel).
- ota_en, output, 1, enables OTA output tri-state driver.
- ota_op, input, 1, OTA positive-side output (asynchronous to clk).
- ota_act, input, 1, OTA enable/activity node (outputs disagree = actively driving), asynchronous.
- res_valid, output, 1, result available.
- res_ready, input, 1, consumer accepts result.
- res_ch, output, SELW, channel index of result.
- res_high, output, CW, count of cycles with sync ota_op=1 and sync ota_act=1.
- res_act, output, CW, count of cycles with sync ota_act=1.
- busy, output, 1, high in any state except IDLE.

Behaviour:
- Reset: state=IDLE, all outputs 0, RR pointer=0, counters=0, synchronizer flops=0. Reset is asynchronous and valid in any state. It aborts the transaction with no result produced.
- ota_op and ota_act each pass through a 2-flop synchronizer before any use.
- FSM states: IDLE, SETTLE, MEASURE, REPORT.
- IDLE:
  - If any ch_req is set, grant the first requester at or after the RR pointer (wrapping modulo NCH).
  - Next cycle: state=SETTLE, ch_gnt one-hot, ota_sel=index, ota_en=1, RR pointer=index+1 mod NCH.
  - No request: stay in IDLE.
- SETTLE: lasts exactly SETTLE cycles (down-counter). Counters are cleared. Transition to MEASURE.
- MEASURE:
  - Lasts exactly WIN cycles.
  - Each cycle: res_act += sync_act; res_high += sync_op & sync_act.
  - Counters cannot overflow because CW covers WIN.
  - After the last sample, go to REPORT.
- REPORT:
  - On entry: ch_gnt=0, ota_en=0, ota_sel holds; res_valid=1, res_ch/res_high/res_act stable.
  - Hold all result outputs until res_valid & res_ready. Next cycle: res_valid=0, state=IDLE.
- Result outputs keep their last values outside REPORT; consumers use them only while res_valid=1.
- Latency: ch_req sampled high in IDLE at cycle T gives res_valid at T+1+SETTLE+WIN when no backpressure.
- After a handshake, one IDLE cycle always precedes the next grant.
- ch_req dropping mid-transaction is ignored; the transaction completes and reports.
- ch_req of the granted channel held high gives it another turn only after all other requesters have been served (RR).
- Simultaneous requests resolve strictly by RR order from the pointer.
- res_ready high before REPORT has no effect.

Test Plan:
- Only ch_req[2]=1, ota_op=ota_act=1 constant, defaults → ch_gnt=4'b0100 and ota_sel=2 at T+1; res_valid at T+69; res_ch=2, res_high=64, res_act=64.
- ch_req=4'b1111 held, res_ready=1 → grant order 0,1,2,3,0; each res_valid separated by 70 cycles (69 plus 1 IDLE).
- ota_act=1, ota_op toggling every cycle → res_high=32, res_act=64. Then ota_act=0 → res_high=0, res_act=0.
- res_ready=0 for 10 cycles in REPORT → res_valid held 10 cycles with outputs stable; ota_en=0 and ch_gnt=0 throughout; accepted on the first cycle ready=1.
- rst pulsed during MEASURE cycle 20 → all outputs 0 immediately (asynchronous); no res_valid; next grant after reset uses RR pointer 0.
- ch_req[1] pulsed one cycle only, with ch_req[3] rising 5 cycles later → ch1 transaction completes with res_ch=1, then ch3 granted.

Source files
------------

// File: rtl/digi_ota_scheduler_if.sv
// Result port of the OTA scheduler: valid/ready handshake carrying the
// channel index and the two sample counts of one measurement window.
interface digi_ota_scheduler_if #(
    parameter int SELW = 2,
    parameter int CW   = 7
);
    logic            res_valid;
    logic            res_ready;
    logic [SELW-1:0] res_ch;
    logic [CW-1:0]   res_high;
    logic [CW-1:0]   res_act;

    modport master (
        output res_valid,
        output res_ch,
        output res_high,
        output res_act,
        input  res_ready
    );

    modport slave (
        input  res_valid,
        input  res_ch,
        input  res_high,
        input  res_act,
        output res_ready
    );
endinterface

// File: rtl/digi_ota_scheduler.sv
// Time-shares one digital OTA/comparator core between NCH channels.
// A round-robin arbiter picks a requester, the FSM steers the OTA mux to it,
// waits for the analog path to settle, counts synchronized OTA activity over
// a fixed window and hands the counts out through a valid/ready port.
module digi_ota_scheduler #(
    parameter int NCH    = 4,
    parameter int SETTLE = 4,
    parameter int WIN    = 64,
    parameter int SELW   = $clog2(NCH),
    parameter int CW     = $clog2(WIN + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCH-1:0]         ch_req,
    output logic [NCH-1:0]         ch_gnt,
    output logic [SELW-1:0]        ota_sel,
    output logic                   ota_en,
    input  logic                   ota_op,
    input  logic                   ota_act,
    output logic                   busy,
    digi_ota_scheduler_if.master   res
);

    // The shared timer counts both the settle and the window phase.
    localparam int TMAX = (SETTLE > WIN) ? SETTLE : WIN;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_MEASURE,
        S_REPORT
    } state_t;

    state_t          state;
    logic [SELW-1:0] ptr;
    logic [TW-1:0]   tmr;
    logic [CW-1:0]   cnt_high;
    logic [CW-1:0]   cnt_act;
    logic [1:0]      op_sync;
    logic [1:0]      act_sync;
    logic            sync_op;
    logic            sync_act;
    logic            found;
    logic [SELW-1:0] pick;
    logic [SELW-1:0] next_ptr;

    logic            out_valid;
    logic [SELW-1:0] out_ch;
    logic [CW-1:0]   out_high;
    logic [CW-1:0]   out_act;

    assign sync_op  = op_sync[1];
    assign sync_act = act_sync[1];

    assign res.res_valid = out_valid;
    assign res.res_ch    = out_ch;
    assign res.res_high  = out_high;
    assign res.res_act   = out_act;

    // Two-flop synchronizers for the OTA outputs, which are asynchronous to clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_sync  <= 2'b00;
            act_sync <= 2'b00;
        end else begin
            op_sync  <= {op_sync[0], ota_op};
            act_sync <= {act_sync[0], ota_act};
        end
    end

    // Round-robin pick: scanning downwards lets the smallest offset from ptr win.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (ch_req[(int'(ptr) + i) % NCH]) begin
                found = 1'b1;
                pick  = SELW'((int'(ptr) + i) % NCH);
            end
        end
    end

    assign next_ptr = SELW'((int'(pick) + 1) % NCH);

    // Main sequencer: grant, settle, measure, report; all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            ptr       <= '0;
            tmr       <= '0;
            cnt_high  <= '0;
            cnt_act   <= '0;
            ch_gnt    <= '0;
            ota_sel   <= '0;
            ota_en    <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_high  <= '0;
            out_act   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (found) begin
                        state   <= S_SETTLE;
                        ch_gnt  <= {{(NCH-1){1'b0}}, 1'b1} << pick;
                        ota_sel <= pick;
                        ota_en  <= 1'b1;
                        busy    <= 1'b1;
                        ptr     <= next_ptr;
                        tmr     <= TW'(SETTLE - 1);
                    end
                end
                S_SETTLE: begin
                    cnt_high <= '0;
                    cnt_act  <= '0;
                    if (tmr == '0) begin
                        state <= S_MEASURE;
                        tmr   <= TW'(WIN - 1);
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                S_MEASURE: begin
                    cnt_act  <= cnt_act + CW'(sync_act);
                    cnt_high <= cnt_high + CW'(sync_op & sync_act);
                    if (tmr == '0) begin
                        state     <= S_REPORT;
                        ch_gnt    <= '0;
                        ota_en    <= 1'b0;
                        out_valid <= 1'b1;
                        out_ch    <= ota_sel;
                        out_act   <= cnt_act + CW'(sync_act);
                        out_high  <= cnt_high + CW'(sync_op & sync_act);
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                S_REPORT: begin
                    if (res.res_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_digi_ota_scheduler.sv
// Directed bench for digi_ota_scheduler with default parameters
// (NCH=4, SETTLE=4, WIN=64): table of single transactions plus hand-written
// sequences for backpressure, reset abort, round-robin fairness and short pulses.
module tb_digi_ota_scheduler;

    logic       clk;
    logic       rst;
    logic [3:0] ch_req;
    logic [3:0] ch_gnt;
    logic [1:0] ota_sel;
    logic       ota_en;
    logic       ota_op;
    logic       ota_act;
    logic       busy;
    logic       toggle_en;

    int n_checks;
    int n_fail;

    digi_ota_scheduler_if #(.SELW(2), .CW(7)) res_if ();

    digi_ota_scheduler dut (
        .clk     (clk),
        .rst     (rst),
        .ch_req  (ch_req),
        .ch_gnt  (ch_gnt),
        .ota_sel (ota_sel),
        .ota_en  (ota_en),
        .ota_op  (ota_op),
        .ota_act (ota_act),
        .busy    (busy),
        .res     (res_if)
    );

    typedef struct {
        logic [3:0] req;
        logic       op;
        logic       toggle;
        logic       act;
        int         hold;
        logic [3:0] exp_gnt;
        int         exp_ch;
        int         exp_high;
        int         exp_act;
    } vec_t;

    vec_t vecs [5];

    // 100 MHz style free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Toggles ota_op every cycle while enabled, giving a 50% duty pattern.
    always @(negedge clk) begin
        if (toggle_en) ota_op = ~ota_op;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic waitIdle();
        int k;
        k = 0;
        while ((busy || res_if.res_valid) && k < 300) begin
            @(negedge clk);
            k++;
        end
        checkOutput("idle_reached", {31'd0, busy}, 32'd0);
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        int k;
        int stable;
        logic [31:0] h0, a0, c0;
        @(negedge clk);
        ota_op    = v.op;
        ota_act   = v.act;
        toggle_en = v.toggle;
        ch_req    = v.req;
        res_if.res_ready = 1'b0;
        @(negedge clk);
        checkOutput($sformatf("v%0d_gnt", idx), {28'd0, ch_gnt}, {28'd0, v.exp_gnt});
        checkOutput($sformatf("v%0d_sel", idx), {30'd0, ota_sel}, v.exp_ch);
        checkOutput($sformatf("v%0d_en", idx), {31'd0, ota_en}, 32'd1);
        checkOutput($sformatf("v%0d_busy", idx), {31'd0, busy}, 32'd1);
        ch_req = 4'b0000;
        k = 0;
        while (!res_if.res_valid && k < 200) begin
            @(negedge clk);
            k++;
        end
        checkOutput($sformatf("v%0d_latency", idx), k, 32'd68);
        checkOutput($sformatf("v%0d_res_ch", idx), {30'd0, res_if.res_ch}, v.exp_ch);
        checkOutput($sformatf("v%0d_res_high", idx), {25'd0, res_if.res_high}, v.exp_high);
        checkOutput($sformatf("v%0d_res_act", idx), {25'd0, res_if.res_act}, v.exp_act);
        checkOutput($sformatf("v%0d_rep_gnt", idx), {28'd0, ch_gnt}, 32'd0);
        checkOutput($sformatf("v%0d_rep_en", idx), {31'd0, ota_en}, 32'd0);
        checkOutput($sformatf("v%0d_rep_sel", idx), {30'd0, ota_sel}, v.exp_ch);
        h0 = {25'd0, res_if.res_high};
        a0 = {25'd0, res_if.res_act};
        c0 = {30'd0, res_if.res_ch};
        stable = 0;
        for (int i = 0; i < v.hold; i++) begin
            @(negedge clk);
            if (res_if.res_valid && ch_gnt == 4'd0 && !ota_en &&
                {25'd0, res_if.res_high} == h0 && {25'd0, res_if.res_act} == a0 &&
                {30'd0, res_if.res_ch} == c0)
                stable++;
        end
        if (v.hold > 0)
            checkOutput($sformatf("v%0d_hold_stable", idx), stable, v.hold);
        res_if.res_ready = 1'b1;
        @(negedge clk);
        checkOutput($sformatf("v%0d_valid_drop", idx), {31'd0, res_if.res_valid}, 32'd0);
        checkOutput($sformatf("v%0d_idle", idx), {31'd0, busy}, 32'd0);
        res_if.res_ready = 1'b0;
        toggle_en = 1'b0;
    endtask

    initial begin
        int k;
        int gnt_seen [$];
        int valid_t [$];
        logic prev_gnt, prev_valid;

        n_checks = 0;
        n_fail   = 0;
        rst       = 1'b1;
        ch_req    = 4'b0000;
        ota_op    = 1'b0;
        ota_act   = 1'b0;
        toggle_en = 1'b0;
        res_if.res_ready = 1'b0;

        // Pointer evolution: 0 -> 3 -> 1 -> 2 -> 0 -> 1 across these vectors.
        vecs[0] = '{req: 4'b0100, op: 1'b1, toggle: 1'b0, act: 1'b1, hold: 0,  exp_gnt: 4'b0100, exp_ch: 2, exp_high: 64, exp_act: 64};
        vecs[1] = '{req: 4'b0011, op: 1'b0, toggle: 1'b1, act: 1'b1, hold: 0,  exp_gnt: 4'b0001, exp_ch: 0, exp_high: 32, exp_act: 64};
        vecs[2] = '{req: 4'b0011, op: 1'b1, toggle: 1'b0, act: 1'b0, hold: 0,  exp_gnt: 4'b0010, exp_ch: 1, exp_high: 0,  exp_act: 0};
        vecs[3] = '{req: 4'b1001, op: 1'b0, toggle: 1'b0, act: 1'b1, hold: 10, exp_gnt: 4'b1000, exp_ch: 3, exp_high: 0,  exp_act: 64};
        vecs[4] = '{req: 4'b1001, op: 1'b1, toggle: 1'b0, act: 1'b1, hold: 0,  exp_gnt: 4'b0001, exp_ch: 0, exp_high: 64, exp_act: 64};

        repeat (3) @(negedge clk);
        checkOutput("rst_gnt", {28'd0, ch_gnt}, 32'd0);
        checkOutput("rst_valid", {31'd0, res_if.res_valid}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_no_req_busy", {31'd0, busy}, 32'd0);

        for (int i = 0; i < 5; i++) applyStimulus(vecs[i], i);

        // Reset during MEASURE: pointer is 1, so channel 1 is granted.
        $display("[TB] reset abort during measure");
        @(negedge clk);
        ota_op = 1'b1;
        ota_act = 1'b1;
        ch_req = 4'b0010;
        @(negedge clk);
        ch_req = 4'b0000;
        checkOutput("ab_gnt", {28'd0, ch_gnt}, 32'd2);
        repeat (24) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("ab_gnt0", {28'd0, ch_gnt}, 32'd0);
        checkOutput("ab_en0", {31'd0, ota_en}, 32'd0);
        checkOutput("ab_sel0", {30'd0, ota_sel}, 32'd0);
        checkOutput("ab_busy0", {31'd0, busy}, 32'd0);
        checkOutput("ab_valid0", {31'd0, res_if.res_valid}, 32'd0);
        checkOutput("ab_high0", {25'd0, res_if.res_high}, 32'd0);
        checkOutput("ab_act0", {25'd0, res_if.res_act}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        k = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (res_if.res_valid) k++;
        end
        checkOutput("ab_no_result", k, 32'd0);

        // All channels requesting with ready held high: strict RR from pointer 0.
        $display("[TB] round robin with all requests");
        res_if.res_ready = 1'b1;
        ch_req = 4'b1111;
        prev_gnt = 1'b0;
        prev_valid = 1'b0;
        for (int c = 0; c < 500 && valid_t.size() < 5; c++) begin
            @(negedge clk);
            if (ch_gnt != 4'd0 && !prev_gnt) gnt_seen.push_back(int'(ota_sel));
            if (res_if.res_valid && !prev_valid) valid_t.push_back(c);
            prev_gnt = (ch_gnt != 4'd0);
            prev_valid = res_if.res_valid;
        end
        ch_req = 4'b0000;
        checkOutput("rr_grants", gnt_seen.size(), 32'd5);
        checkOutput("rr_results", valid_t.size(), 32'd5);
        for (int i = 0; i < 5; i++)
            if (gnt_seen.size() > i) checkOutput($sformatf("rr_order%0d", i), gnt_seen[i], i % 4);
        for (int i = 1; i < 5; i++)
            if (valid_t.size() > i) checkOutput($sformatf("rr_gap%0d", i), valid_t[i] - valid_t[i-1], 32'd70);
        waitIdle();

        // One-cycle pulse on ch1, ch3 rising 5 cycles later while ch1 is in flight.
        $display("[TB] short request pulse");
        @(negedge clk);
        ch_req = 4'b0010;
        @(negedge clk);
        ch_req = 4'b0000;
        checkOutput("pl_gnt1", {28'd0, ch_gnt}, 32'd2);
        repeat (4) @(negedge clk);
        ch_req = 4'b1000;
        k = 0;
        while (!res_if.res_valid && k < 200) begin
            @(negedge clk);
            k++;
        end
        checkOutput("pl_res_ch1", {30'd0, res_if.res_ch}, 32'd1);
        checkOutput("pl_gnt_in_report", {28'd0, ch_gnt}, 32'd0);
        k = 0;
        while (ch_gnt == 4'd0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        checkOutput("pl_gnt3", {28'd0, ch_gnt}, 32'd8);
        ch_req = 4'b0000;
        k = 0;
        while (!res_if.res_valid && k < 200) begin
            @(negedge clk);
            k++;
        end
        checkOutput("pl_res_ch3", {30'd0, res_if.res_ch}, 32'd3);
        waitIdle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
